uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver for the uart_app design, the receive-side counterpart of the transmit path. It consumes the 16x oversampling tick from the baud generator, recovers 8N1 frames from the asynchronous RX line, and presents each byte as a one-cycle valid pulse. Framing errors are flagged, and the receiver re-arms only after the line returns to idle.

## Interface
- DataBits, default 8, number of data bits per frame, LSB first.
- OversampleRate, default 16, SamplingTick pulses per bit period; must be even and at least 4.
- Clock  input  1  system clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- SamplingTick  input  1  one-Clock-wide pulse at OversampleRate x baud, from the baud generator.
- RxSerial  input  1  asynchronous serial line; idles high.
- DataOut  output  DataBits  last correctly received byte; holds its value until the next valid frame.
- DataValid  output  1  one-Clock pulse when DataOut is updated.
- FramingError  output  1  one-Clock pulse when the stop bit is sampled low.
- Busy  output  1  high while the state is not IDLE.

## Operation
- RxSerial passes through a 2-flop synchronizer. All decisions use the synchronized bit RxSync.
- Two counters advance only on cycles where SamplingTick=1:
  - TickCount, width clog2(OversampleRate).
  - BitCount, width clog2(DataBits).
- States: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY when the Configuration macro is defined).
- IDLE: when RxSync=0 on a SamplingTick, clear TickCount and go to START.
- START: at TickCount = OversampleRate/2-1 (mid start bit):
  - RxSync=0: clear TickCount and BitCount, go to DATA.
  - RxSync=1: false start (glitch); return to IDLE with no outputs.
- DATA: at TickCount = OversampleRate-1:
  - Shift RxSync into the MSB of the shift register (LSB-first reception) and clear TickCount.
  - After the DataBits-th bit, go to STOP.
- STOP: at TickCount = OversampleRate-1:
  - RxSync=1: load DataOut from the shift register, pulse DataValid, go to IDLE.
  - RxSync=0: pulse FramingError, leave DataOut unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until RxSync=1 on a SamplingTick, then go to IDLE. A break condition therefore produces exactly one FramingError.
- DataValid and FramingError are never high in the same cycle.
- Back-to-back frames: a start bit that begins immediately after the stop-bit sample is detected in IDLE without loss. The receiver returns to IDLE mid stop bit, half a bit early.

## Timing
- Reset values: state IDLE, counters 0, DataOut 0, DataValid 0, FramingError 0, Busy 0, synchronizer flops 1.
- Reset mid-frame aborts the frame with no pulse. The next frame is received normally.
- Input latency: 2 Clock cycles of synchronizer delay before an RxSerial edge is seen.
- Output latency: DataValid or FramingError is registered and asserts in the Clock cycle after the SamplingTick on which the stop bit is sampled.
- Without SamplingTick, no state or counter changes occur, except the synchronizer and the deassertion of the one-cycle pulses.
- There is no ready/backpressure. A consumer that misses a DataValid pulse loses the byte, although DataOut still holds it.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state sits between DATA and STOP and samples one even-parity bit at TickCount = OversampleRate-1.
  - Output ParityError (1 bit) pulses together with DataValid when the parity check fails.
  - DataOut is still loaded on a parity failure.
  - On a framing error, only FramingError is pulsed.
- UART_RX_PARITY_EN undefined: no PARITY state and no ParityError port; the frame is 8N1.

## Structure
- Shared package uart_package:
  - State enum UartRxState.
  - Constants UART_DEFAULT_OVERSAMPLE=16 and UART_DEFAULT_DATA_BITS=8. These are shared with the transmitter and the baud generator.
- Sub-module uart_bit_synchronizer: 2-flop synchronizer with a reset value of 1, reusable by other asynchronous inputs.

## Test plan
Bench: SamplingTick every 4 Clock cycles, so one bit period is 64 Clock cycles.
- Reset asserted for 3 cycles while RxSerial=0:
  - During reset, all outputs are 0.
  - After release, with RxSerial=1, Busy stays 0.
- Frame 0xA5 (line sequence 0, 1,0,1,0,0,1,0,1, 1) -> one DataValid pulse with DataOut=0xA5 and FramingError=0.
- Low glitch on RxSerial lasting 16 Clock cycles -> the receiver returns to IDLE; no DataValid and no FramingError.
- Frame 0x3C with the stop bit held low for 5 bit periods -> one FramingError pulse, DataOut keeps its previous value 0xA5, and Busy stays 1 until the line goes high.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two DataValid pulses with DataOut=0x00 then 0xFF.
- Reset pulsed in the middle of data bit 4 of 0x5A, then a full 0x81 frame -> no pulse for the aborted frame; DataValid with DataOut=0x81.

Source files
------------

// File: rtl/uart_package.sv
// Shared UART definitions: receiver state encoding and default frame geometry
// used by the receiver, transmitter and baud generator.
package uart_package;

   localparam int UART_DEFAULT_OVERSAMPLE = 16;
   localparam int UART_DEFAULT_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
`ifdef UART_RX_PARITY_EN
      , PARITY
`endif
   } UartRxState;

endpackage

// File: rtl/uart_bit_synchronizer.sv
// Two-flop synchronizer for an asynchronous level; both flops reset high
// so an idle-high line never shows a spurious low after reset.
module uart_bit_synchronizer (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic level
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= 1'b1;
         level <= 1'b1;
      end else begin
         meta  <= line;
         level <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (8N1 by default); define UART_RX_PARITY_EN to
// add an even-parity bit and the ParityError output.
module uart_receiver
   import uart_package::*;
#(
   parameter int DataBits       = UART_DEFAULT_DATA_BITS,
   parameter int OversampleRate = UART_DEFAULT_OVERSAMPLE
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                SamplingTick,
   input  logic                RxSerial,
   output logic [DataBits-1:0] DataOut,
   output logic                DataValid,
   output logic                FramingError,
`ifdef UART_RX_PARITY_EN
   output logic                ParityError,
`endif
   output logic                Busy
);

   localparam int TW = $clog2(OversampleRate);
   localparam int BW = (DataBits > 1) ? $clog2(DataBits) : 1;

   localparam logic [TW-1:0] TICK_MID  = TW'(OversampleRate / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OversampleRate - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DataBits - 1);

   UartRxState state, state_n;
   logic [TW-1:0] tick, tick_n;
   logic [BW-1:0] bit_cnt, bit_n;
   logic [DataBits-1:0] shift, shift_n;
   logic [DataBits-1:0] data_n;
   logic valid_n, ferr_n;
   logic rx_sync;

`ifdef UART_RX_PARITY_EN
   logic parity_bad, parity_bad_n, perr_n;
`endif

   uart_bit_synchronizer u_sync (
      .clk   (Clock),
      .rst   (Reset),
      .line  (RxSerial),
      .level (rx_sync)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         tick         <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         DataOut      <= '0;
         DataValid    <= 1'b0;
         FramingError <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad   <= 1'b0;
         ParityError  <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         tick         <= tick_n;
         bit_cnt      <= bit_n;
         shift        <= shift_n;
         DataOut      <= data_n;
         DataValid    <= valid_n;
         FramingError <= ferr_n;
`ifdef UART_RX_PARITY_EN
         parity_bad   <= parity_bad_n;
         ParityError  <= perr_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick;
      bit_n   = bit_cnt;
      shift_n = shift;
      data_n  = DataOut;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_n = parity_bad;
      perr_n       = 1'b0;
`endif
      if (SamplingTick) begin
         unique case (state)
            IDLE: begin
               if (!rx_sync) begin
                  tick_n  = '0;
                  state_n = START;
               end
            end
            START: begin
               if (tick == TICK_MID) begin
                  tick_n  = '0;
                  bit_n   = '0;
                  // a high line at mid start bit was only a glitch
                  state_n = rx_sync ? IDLE : DATA;
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
            DATA: begin
               if (tick == TICK_LAST) begin
                  tick_n  = '0;
                  shift_n = {rx_sync, shift[DataBits-1:1]};
                  if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end else begin
                     bit_n = bit_cnt + 1'b1;
                  end
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick == TICK_LAST) begin
                  tick_n       = '0;
                  parity_bad_n = (^shift) ^ rx_sync;
                  state_n      = STOP;
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick == TICK_LAST) begin
                  tick_n = '0;
                  if (rx_sync) begin
                     data_n  = shift;
                     valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                     perr_n  = parity_bad;
`endif
                     state_n = IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = WAIT_HIGH;
                  end
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (rx_sync) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: tick every 4 clocks, 64 clocks per bit.
module tb_uart_receiver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sampling_tick = 1'b0;
   logic       rx_serial = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       framing_error;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
`endif

   int tests = 0;
   int fails = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   logic [7:0] last_data = 8'h00;

   uart_receiver dut (
      .Clock        (clock),
      .Reset        (reset),
      .SamplingTick (sampling_tick),
      .RxSerial     (rx_serial),
      .DataOut      (data_out),
      .DataValid    (data_valid),
      .FramingError (framing_error),
`ifdef UART_RX_PARITY_EN
      .ParityError  (parity_error),
`endif
      .Busy         (busy)
   );

   always #5 clock = ~clock;

   initial begin
      forever begin
         repeat (3) @(negedge clock);
         sampling_tick = 1'b1;
         @(negedge clock);
         sampling_tick = 1'b0;
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (data_valid === 1'b1) begin
            valid_cnt++;
            last_data = data_out;
         end
         if (framing_error === 1'b1) ferr_cnt++;
         if (data_valid === 1'b1 && framing_error === 1'b1) both_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_serial = b;
      repeat (64) @(negedge clock);
   endtask

   task automatic send_data(input logic [7:0] d);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
   endtask

   initial begin
      // reset with the line held low
      reset = 1'b1;
      rx_serial = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_data_out", {24'h0, data_out}, 32'h0);
      chk("rst_valid", {31'h0, data_valid}, 32'h0);
      chk("rst_ferr", {31'h0, framing_error}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      rx_serial = 1'b1;
      repeat (40) @(negedge clock);
      chk("post_rst_busy", {31'h0, busy}, 32'h0);
      chk("post_rst_valid_cnt", valid_cnt, 0);

      // frame 0xA5
      send_bit(1'b1);
      send_data(8'hA5);
      send_bit(1'b1);
      send_bit(1'b1);
      chk("a5_valid_cnt", valid_cnt, 1);
      chk("a5_data", {24'h0, last_data}, 32'hA5);
      chk("a5_data_out", {24'h0, data_out}, 32'hA5);
      chk("a5_ferr_cnt", ferr_cnt, 0);
      chk("a5_busy", {31'h0, busy}, 32'h0);

      // 16-clock low glitch
      rx_serial = 1'b0;
      repeat (16) @(negedge clock);
      rx_serial = 1'b1;
      repeat (128) @(negedge clock);
      chk("glitch_valid_cnt", valid_cnt, 1);
      chk("glitch_ferr_cnt", ferr_cnt, 0);
      chk("glitch_busy", {31'h0, busy}, 32'h0);

      // 0x3C with stop bit low for 5 bit periods
      send_data(8'h3C);
      rx_serial = 1'b0;
      repeat (128) @(negedge clock);
      chk("brk_ferr_cnt_mid", ferr_cnt, 1);
      chk("brk_busy_mid", {31'h0, busy}, 32'h1);
      repeat (192) @(negedge clock);
      chk("brk_busy_end", {31'h0, busy}, 32'h1);
      chk("brk_ferr_cnt_end", ferr_cnt, 1);
      chk("brk_valid_cnt", valid_cnt, 1);
      chk("brk_data_out", {24'h0, data_out}, 32'hA5);
      send_bit(1'b1);
      chk("brk_busy_after", {31'h0, busy}, 32'h0);
      chk("brk_ferr_cnt_after", ferr_cnt, 1);

      // back-to-back 0x00 then 0xFF
      send_data(8'h00);
      send_bit(1'b1);
      chk("b2b0_valid_cnt", valid_cnt, 2);
      chk("b2b0_data", {24'h0, last_data}, 32'h00);
      send_data(8'hFF);
      send_bit(1'b1);
      send_bit(1'b1);
      chk("b2b1_valid_cnt", valid_cnt, 3);
      chk("b2b1_data", {24'h0, last_data}, 32'hFF);
      chk("b2b_ferr_cnt", ferr_cnt, 1);

      // reset in the middle of data bit 4 of 0x5A
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      rx_serial = 1'b1;
      repeat (32) @(negedge clock);
      chk("abort_busy_pre", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("abort_busy_rst", {31'h0, busy}, 32'h0);
      chk("abort_data_out", {24'h0, data_out}, 32'h0);
      repeat (128) @(negedge clock);
      chk("abort_valid_cnt", valid_cnt, 3);
      chk("abort_ferr_cnt", ferr_cnt, 1);

      // 0x81 after the aborted frame
      send_data(8'h81);
      send_bit(1'b1);
      send_bit(1'b1);
      chk("x81_valid_cnt", valid_cnt, 4);
      chk("x81_data", {24'h0, last_data}, 32'h81);
      chk("x81_data_out", {24'h0, data_out}, 32'h81);
      chk("x81_ferr_cnt", ferr_cnt, 1);
      chk("never_both", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
